// File: rtl/aib_mac_traffic_gen.sv
// aib_mac_traffic_gen
// MAC-side traffic generator for AIB bring-up. After a start request it
// latches mode/mask/length, waits for the link handshake on every enabled
// channel, sends MARKER_BEATS alignment beats, then a counted or continuous
// sequence-numbered payload burst.
//
// Ports:
//   wr_clk, wr_rst       clock, asynchronous active-high reset
//   i_start, i_stop      single-cycle start / stop requests
//   i_mode               beat size: 0=GEN1 (1 sub-word), 1=GEN2 (2), 2=FIFO 2:1 (4), 3=FIFO 4:1 (8)
//   i_chnl_en            channel enable mask
//   i_burst_len          payload beats, 0 = continuous
//   ns_mac_rdy, fs_mac_rdy, ms_tx_transfer_en   per-channel link handshake
//   data_out             beat data, channel c at [c*8*DWIDTH +: 8*DWIDTH]
//   o_valid, o_marker    per-channel beat valid, marker beat flag
//   o_busy, o_done       not idle, one-cycle burst completion pulse
//   o_abort              sticky abort (ready timeout or ready lost)
//   o_beat_cnt           payload beats sent in current/last burst
module aib_mac_traffic_gen #(
  parameter int                TOTAL_CHNL_NUM = 24,
  parameter int                DWIDTH         = 40,
  parameter logic [DWIDTH-1:0] MARKER         = DWIDTH'(40'hA5A5_5A5A_C3),
  parameter int                MARKER_BEATS   = 4,
  parameter int                RDY_TIMEOUT    = 1024
) (
  input  logic                               wr_clk,
  input  logic                               wr_rst,
  input  logic                               i_start,
  input  logic                               i_stop,
  input  logic [1:0]                         i_mode,
  input  logic [TOTAL_CHNL_NUM-1:0]          i_chnl_en,
  input  logic [15:0]                        i_burst_len,
  input  logic [TOTAL_CHNL_NUM-1:0]          ns_mac_rdy,
  input  logic [TOTAL_CHNL_NUM-1:0]          fs_mac_rdy,
  input  logic [TOTAL_CHNL_NUM-1:0]          ms_tx_transfer_en,
  output logic [TOTAL_CHNL_NUM*DWIDTH*8-1:0] data_out,
  output logic [TOTAL_CHNL_NUM-1:0]          o_valid,
  output logic                               o_marker,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_abort,
  output logic [15:0]                        o_beat_cnt
);
  localparam int BW = 8 * DWIDTH;
  localparam int SW = DWIDTH - 8;
  localparam int MW = $clog2(MARKER_BEATS + 1);
  localparam int TW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_RDY, MARK, RUN, DONE} state_t;

  state_t                          state_q, state_n;
  logic [1:0]                      mode_q, mode_n;
  logic [TOTAL_CHNL_NUM-1:0]       mask_q, mask_n;
  logic [15:0]                     len_q, len_n;
  logic [SW-1:0]                   seq_q, seq_n;
  logic [MW-1:0]                   mcnt_q, mcnt_n;
  logic [TW-1:0]                   tmr_q, tmr_n;
  logic [TOTAL_CHNL_NUM*BW-1:0]    data_n, marker_data, payload_data;
  logic [TOTAL_CHNL_NUM-1:0]       valid_n;
  logic                            marker_n, done_n, abort_n;
  logic [15:0]                     beat_n;
  logic [7:0]                      sub_en;
  logic [SW-1:0]                   seq_step;
  logic                            ready;

  // Disabled channels count as ready, so an all-zero mask is vacuously ready.
  assign ready = &(~mask_q | (ns_mac_rdy & fs_mac_rdy & ms_tx_transfer_en));

  always_comb begin
    sub_en   = 8'h01;
    seq_step = SW'(1);
    case (mode_q)
      2'd1:    begin sub_en = 8'h03; seq_step = SW'(2); end
      2'd2:    begin sub_en = 8'h0F; seq_step = SW'(4); end
      2'd3:    begin sub_en = 8'hFF; seq_step = SW'(8); end
      default: begin sub_en = 8'h01; seq_step = SW'(1); end
    endcase
  end

  // Candidate beats built from the latched configuration; the FSM picks one.
  always_comb begin
    marker_data  = '0;
    payload_data = '0;
    for (int c = 0; c < TOTAL_CHNL_NUM; c++) begin
      for (int k = 0; k < 8; k++) begin
        if (mask_q[c] && sub_en[k]) begin
          marker_data[c*BW + k*DWIDTH +: DWIDTH]  = MARKER;
          payload_data[c*BW + k*DWIDTH +: DWIDTH] = {8'(c), seq_q + SW'(k)};
        end
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    mask_n   = mask_q;
    len_n    = len_q;
    seq_n    = seq_q;
    mcnt_n   = mcnt_q;
    tmr_n    = tmr_q;
    beat_n   = o_beat_cnt;
    abort_n  = o_abort;
    data_n   = '0;
    valid_n  = '0;
    marker_n = 1'b0;
    done_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_stop) begin
          mode_n  = i_mode;
          mask_n  = i_chnl_en;
          len_n   = i_burst_len;
          seq_n   = '0;
          beat_n  = '0;
          abort_n = 1'b0;
          tmr_n   = TW'(RDY_TIMEOUT - 1);
          state_n = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (ready) begin
          state_n  = MARK;
          mcnt_n   = MW'(1);
          valid_n  = mask_q;
          marker_n = 1'b1;
          data_n   = marker_data;
        end else if (tmr_q == '0) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      MARK: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (!ready) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (mcnt_q < MW'(MARKER_BEATS)) begin
          mcnt_n   = mcnt_q + 1'b1;
          valid_n  = mask_q;
          marker_n = 1'b1;
          data_n   = marker_data;
        end else begin
          state_n = RUN;
          valid_n = mask_q;
          data_n  = payload_data;
          seq_n   = seq_q + seq_step;
          beat_n  = o_beat_cnt + 16'd1;
        end
      end
      RUN: begin
        if (i_stop) begin
          state_n = IDLE;
        end else if (!ready) begin
          abort_n = 1'b1;
          state_n = IDLE;
        end else if (len_q != 16'd0 && o_beat_cnt == len_q) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          valid_n = mask_q;
          data_n  = payload_data;
          seq_n   = seq_q + seq_step;
          beat_n  = o_beat_cnt + 16'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      mask_q     <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      mcnt_q     <= '0;
      tmr_q      <= '0;
      data_out   <= '0;
      o_valid    <= '0;
      o_marker   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_abort    <= 1'b0;
      o_beat_cnt <= '0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      mask_q     <= mask_n;
      len_q      <= len_n;
      seq_q      <= seq_n;
      mcnt_q     <= mcnt_n;
      tmr_q      <= tmr_n;
      data_out   <= data_n;
      o_valid    <= valid_n;
      o_marker   <= marker_n;
      o_busy     <= (state_n != IDLE);
      o_done     <= done_n;
      o_abort    <= abort_n;
      o_beat_cnt <= beat_n;
    end
  end
endmodule

// File: tb/tb_aib_mac_traffic_gen.sv
module tb_aib_mac_traffic_gen;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int SW = DW - 8;
  localparam int BW = 8 * DW;
  localparam int MB = 4;
  localparam int TO = 16;
  localparam logic [DW-1:0] MK = 16'h5AC3;

  typedef struct {
    logic [CH-1:0]    valid;
    logic             marker;
    logic [CH*BW-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0, stop = 1'b0;
  logic [1:0]        mode = '0;
  logic [CH-1:0]     chnl_en = '0;
  logic [15:0]       burst_len = '0;
  logic [CH-1:0]     ns_rdy = '1, fs_rdy = '1, tx_en = '1;
  logic [CH*BW-1:0]  data_out;
  logic [CH-1:0]     valid;
  logic              marker, busy, done, abort;
  logic [15:0]       beat_cnt;

  beat_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;

  aib_mac_traffic_gen #(
    .TOTAL_CHNL_NUM(CH), .DWIDTH(DW), .MARKER_BEATS(MB), .RDY_TIMEOUT(TO)
  ) dut (
    .wr_clk(clk), .wr_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_chnl_en(chnl_en), .i_burst_len(burst_len), .ns_mac_rdy(ns_rdy),
    .fs_mac_rdy(fs_rdy), .ms_tx_transfer_en(tx_en), .data_out(data_out),
    .o_valid(valid), .o_marker(marker), .o_busy(busy), .o_done(done),
    .o_abort(abort), .o_beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int m, input logic [CH-1:0] msk, input bit is_mk, input int seq);
    beat_t b;
    b.valid  = msk;
    b.marker = is_mk;
    b.data   = '0;
    for (int c = 0; c < CH; c++)
      if (msk[c])
        for (int k = 0; k < (1 << m); k++)
          b.data[c*BW + k*DW +: DW] = is_mk ? MK : {8'(c), SW'((seq + k) % (1 << SW))};
    return b;
  endfunction

  task automatic push_burst(input int m, input logic [CH-1:0] msk, input int npay);
    for (int i = 0; i < MB; i++) exp_q.push_back(mk_beat(m, msk, 1'b1, 0));
    for (int i = 0; i < npay; i++) exp_q.push_back(mk_beat(m, msk, 1'b0, i * (1 << m)));
  endtask

  task automatic do_start(input logic [1:0] m, input logic [CH-1:0] msk, input logic [15:0] len);
    mode = m; chnl_en = msk; burst_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (beat_cnt == target) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_beat_cnt timeout: beat_cnt %0d required %0d", beat_cnt, target);
    end
  endtask

  task automatic wait_done(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done timeout: o_done %0b required 1", done);
    end
  endtask

  // Monitor: pops one expected beat whenever any channel presents valid.
  always @(negedge clk) begin
    beat_t e;
    if (done) done_cnt++;
    if (valid !== '0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: valid %b marker %b with nothing expected", valid, marker);
      end else begin
        e = exp_q.pop_front();
        if (valid !== e.valid || marker !== e.marker || data_out !== e.data) begin
          n_fail++;
          $display("FAIL beat: got valid=%b marker=%b data=%h expected valid=%b marker=%b data=%h",
                   valid, marker, data_out, e.valid, e.marker, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", data_out == '0, 1'b1);
    chk("reset_flags", {valid, marker, busy, done, abort}, '0);
    chk("reset_beat_cnt", beat_cnt, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // GEN2, all channels, 3 payload beats
    d0 = done_cnt;
    push_burst(1, 4'hF, 3);
    do_start(2'd1, 4'hF, 16'd3);
    chk("t1_busy", busy, 1'b1);
    wait_done(40);
    chk("t1_beat_cnt", beat_cnt, 16'd3);
    chk("t1_valid_in_done", valid, 4'h0);
    @(negedge clk);
    chk("t1_idle", {busy, done}, 2'b00);
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_done_once", done_cnt - d0, 1);

    // FIFO 4:1, sparse mask, single payload beat
    push_burst(3, 4'b0101, 1);
    do_start(2'd3, 4'b0101, 16'd1);
    wait_done(40);
    chk("t2_beat_cnt", beat_cnt, 16'd1);
    @(negedge clk);
    chk("t2_drain", exp_q.size(), 0);

    // ready timeout: exactly TO cycles in WAIT_RDY
    fs_rdy[1] = 1'b0;
    do_start(2'd0, 4'hF, 16'd5);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      chk("t3_waiting", {abort, busy}, 2'b01);
    end
    @(negedge clk);
    chk("t3_abort", {abort, busy, valid}, {1'b1, 1'b0, 4'h0});
    chk("t3_data_zero", data_out == '0, 1'b1);
    fs_rdy = '1;
    @(negedge clk);

    // continuous run, ready lost after 10 payload beats
    d0 = done_cnt;
    push_burst(0, 4'hF, 10);
    do_start(2'd0, 4'hF, 16'd0);
    chk("t4_abort_cleared", abort, 1'b0);
    wait_cnt(16'd10, 40);
    tx_en[0] = 1'b0;
    @(negedge clk);
    chk("t4_abort", {abort, busy, valid}, {1'b1, 1'b0, 4'h0});
    chk("t4_beat_cnt", beat_cnt, 16'd10);
    chk("t4_data_zero", data_out == '0, 1'b1);
    tx_en = '1;
    repeat (2) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_drain", exp_q.size(), 0);

    // start and stop together in IDLE
    mode = 2'd0; chnl_en = 4'hF; burst_len = 16'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t5_stay_idle", busy, 1'b0);
    repeat (6) @(negedge clk);
    chk("t5_still_idle", busy, 1'b0);
    chk("t5_abort_kept", abort, 1'b1);

    // start during RUN is ignored; mode/mask changes have no effect
    push_burst(1, 4'b0010, 6);
    do_start(2'd1, 4'b0010, 16'd6);
    wait_cnt(16'd2, 40);
    mode = 2'd3; chnl_en = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    chk("t6_beat_cnt", beat_cnt, 16'd6);
    @(negedge clk);
    chk("t6_drain", exp_q.size(), 0);
    chk("t6_idle", busy, 1'b0);

    // FIFO 2:1 continuous across the seq wrap, then stop
    d0 = done_cnt;
    push_burst(2, 4'b1000, 66);
    do_start(2'd2, 4'b1000, 16'd0);
    wait_cnt(16'd66, 120);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t7_stop", {busy, abort, valid}, {1'b0, 1'b0, 4'h0});
    chk("t7_beat_cnt", beat_cnt, 16'd66);
    chk("t7_drain", exp_q.size(), 0);
    @(negedge clk);
    chk("t7_no_done", done_cnt - d0, 0);

    // all-zero mask: runs to completion with no valid beats
    do_start(2'd0, 4'b0000, 16'd2);
    wait_done(40);
    chk("t8_beat_cnt", beat_cnt, 16'd2);
    @(negedge clk);
    chk("t8_idle", busy, 1'b0);

    // asynchronous reset mid-RUN
    push_burst(0, 4'hF, 3);
    do_start(2'd0, 4'hF, 16'd0);
    wait_cnt(16'd3, 40);
    #2 rst = 1'b1;
    #1;
    chk("t9_async_flags", {valid, marker, busy, done, abort}, '0);
    chk("t9_async_cnt", beat_cnt, 16'd0);
    chk("t9_async_data", data_out == '0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk("t9_drain", exp_q.size(), 0);

    // recovery after reset
    push_burst(0, 4'b0001, 1);
    do_start(2'd0, 4'b0001, 16'd1);
    wait_done(40);
    chk("t10_beat_cnt", beat_cnt, 16'd1);
    repeat (3) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
